// File: rtl/load_sequencer.sv
// load_sequencer: runs one data-memory load at a time. Validates funct3 and
// alignment, issues a word-aligned read, lane-shifts the returned word, drives
// the shared sign extender and hands back the extended value with its rd tag.
//
// Handshakes: every valid/ready pair transfers on a rising edge where both are
// high; a valid, once raised, stays high with its payload unchanged until that
// transfer happens. mem_rvalid is a one-cycle pulse with no ready.
module load_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [4:0]            req_rd,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [4:0]            sx_op,
    output logic [DATA_WIDTH-1:0] sx_unextended,
    input  logic [DATA_WIDTH-1:0] sx_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [4:0]            rsp_rd,
    output logic [1:0]            rsp_fault,
    output logic                  busy
);

    // Sign extender op codes; SX_3100 (pass-through) is zero so a cleared op
    // register already selects it.
    localparam logic [4:0] SX_3100  = 5'd0;
    localparam logic [4:0] SX_0700  = 5'd1;
    localparam logic [4:0] SX_1500  = 5'd2;
    localparam logic [4:0] SXU_0700 = 5'd3;
    localparam logic [4:0] SXU_1500 = 5'd4;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    // Counter value of the last WAIT cycle before a timeout is declared.
    localparam logic [7:0] TIMEOUT_TERM = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [4:0]            op_q, op_d;
    logic [4:0]            rd_q, rd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            fault_q, fault_d;

    logic [4:0]            dec_op;
    logic                  dec_illegal;
    logic                  dec_misaligned;
    logic [4:0]            lane_shift;

    // Decode the incoming funct3 into an extender op and its fault conditions.
    always_comb begin
        dec_op         = SX_3100;
        dec_illegal    = 1'b0;
        dec_misaligned = 1'b0;
        case (req_funct3)
            3'b000: dec_op = SX_0700;
            3'b001: begin
                dec_op         = SX_1500;
                dec_misaligned = req_addr[0];
            end
            3'b010: begin
                dec_op         = SX_3100;
                dec_misaligned = |req_addr[1:0];
            end
            3'b100: dec_op = SXU_0700;
            3'b101: begin
                dec_op         = SXU_1500;
                dec_misaligned = req_addr[0];
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign lane_shift = {addr_q[1:0], 3'b000};

    // State register and latched load context.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            op_q    <= SX_3100;
            rd_q    <= '0;
            data_q  <= '0;
            fault_q <= FAULT_OK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        op_d    = op_q;
        rd_d    = rd_q;
        data_d  = data_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    rd_d   = req_rd;
                    op_d   = dec_op;
                    data_d = '0;
                    cnt_d  = '0;
                    // Illegal funct3 outranks misalignment; neither touches memory.
                    if (dec_illegal) begin
                        fault_d = FAULT_ILLEGAL;
                        state_d = S_RESP;
                    end else if (dec_misaligned) begin
                        fault_d = FAULT_MISALIGN;
                        state_d = S_RESP;
                    end else begin
                        fault_d = FAULT_OK;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Read data arriving on the terminal count still wins.
                if (mem_rvalid) begin
                    data_d  = mem_rdata >> lane_shift;
                    state_d = S_RESP;
                end else if (cnt_q == TIMEOUT_TERM) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and response outputs, all decoded from registered state.
    always_comb begin
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        busy          = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  req_ready     = 1'b1;
            S_ISSUE: mem_req_valid = 1'b1;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (fault_q == FAULT_OK) begin
                    rsp_data = sx_result;
                end
            end
            default: ;
        endcase
    end

    assign mem_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign sx_op         = op_q;
    assign sx_unextended = data_q;
    assign rsp_rd        = rd_q;
    assign rsp_fault     = fault_q;

endmodule

// File: tb/tb_load_sequencer.sv
// Bench for load_sequencer: a behavioural sign extender, directed loads from
// the load-unit test list, a reset abort, and a short randomised tail.
module tb_load_sequencer;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;
    localparam int EW = 2 + 5 + DW + 5 + DW;

    localparam logic [4:0] SX_3100  = 5'd0;
    localparam logic [4:0] SX_0700  = 5'd1;
    localparam logic [4:0] SX_1500  = 5'd2;
    localparam logic [4:0] SXU_0700 = 5'd3;
    localparam logic [4:0] SXU_1500 = 5'd4;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_funct3;
    logic [4:0]    req_rd;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic [4:0]    sx_op;
    logic [DW-1:0] sx_unextended;
    logic [DW-1:0] sx_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [4:0]    rsp_rd;
    logic [1:0]    rsp_fault;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // {fault, rd, data, sx_op, sx_unextended}
    logic [EW-1:0] exp_q[$];

    load_sequencer #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_funct3   (req_funct3),
        .req_rd       (req_rd),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr     (mem_addr),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .sx_op        (sx_op),
        .sx_unextended(sx_unextended),
        .sx_result    (sx_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_rd       (rsp_rd),
        .rsp_fault    (rsp_fault),
        .busy         (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared sign extender model
    always_comb begin
        case (sx_op)
            SX_0700:  sx_result = {{24{sx_unextended[7]}}, sx_unextended[7:0]};
            SX_1500:  sx_result = {{16{sx_unextended[15]}}, sx_unextended[15:0]};
            SXU_0700: sx_result = {24'd0, sx_unextended[7:0]};
            SXU_1500: sx_result = {16'd0, sx_unextended[15:0]};
            default:  sx_result = sx_unextended;
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete load. rv_delay < 0 means memory never answers.
    task automatic do_load(input logic [AW-1:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [DW-1:0] rdata, input int mem_stall, input int rv_delay,
                           input int rsp_stall);
        logic          illegal;
        logic          mis;
        logic [1:0]    fault;
        logic [DW-1:0] sh;
        logic [DW-1:0] exp_data;
        logic [4:0]    exp_op;
        logic [EW-1:0] entry;
        int            cyc;
        int            waits;

        illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        case (f3)
            3'd1, 3'd5: mis = addr[0];
            3'd2:       mis = (addr[1:0] != 2'b00);
            default:    mis = 1'b0;
        endcase
        fault = illegal ? 2'b10 : mis ? 2'b01 : (rv_delay < 0) ? 2'b11 : 2'b00;
        sh = (fault == 2'b00) ? (rdata >> (8 * int'(addr[1:0]))) : '0;
        case (f3)
            3'd0:    begin exp_op = SX_0700;  exp_data = {{24{sh[7]}}, sh[7:0]};   end
            3'd1:    begin exp_op = SX_1500;  exp_data = {{16{sh[15]}}, sh[15:0]}; end
            3'd4:    begin exp_op = SXU_0700; exp_data = {24'd0, sh[7:0]};         end
            3'd5:    begin exp_op = SXU_1500; exp_data = {16'd0, sh[15:0]};        end
            default: begin exp_op = SX_3100;  exp_data = sh;                       end
        endcase
        if (fault != 2'b00) exp_data = '0;
        exp_q.push_back({fault, rd, exp_data, exp_op, sh});

        check_eq("req_ready_idle", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_funct3 = f3;
        req_rd     = rd;
        tick();
        cyc        = 1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_funct3 = 3'($urandom_range(0, 7));
        req_rd     = 5'($urandom_range(0, 31));

        if (illegal || mis) begin
            check_eq("fault_latency", rsp_valid, 1'b1);
            check_eq("fault_no_mem", mem_req_valid, 1'b0);
        end else begin
            check_eq("issue_valid", mem_req_valid, 1'b1);
            mem_req_ready = 1'b0;
            for (int s = 0; s < mem_stall; s++) begin
                check_eq("issue_addr", mem_addr, {addr[AW-1:2], 2'b00});
                check_eq("issue_hold", mem_req_valid, 1'b1);
                tick();
                cyc++;
            end
            check_eq("issue_addr", mem_addr, {addr[AW-1:2], 2'b00});
            mem_req_ready = 1'b1;
            tick();
            cyc++;
            mem_req_ready = 1'b0;
            waits = 0;
            while (waits < 300) begin
                mem_rvalid = (waits == rv_delay);
                mem_rdata  = mem_rvalid ? rdata : $urandom;
                tick();
                waits++;
                cyc++;
                mem_rvalid = 1'b0;
                if (rsp_valid) break;
                check_eq("wait_no_rsp", mem_req_valid, 1'b0);
            end
            check_eq("rsp_arrived", rsp_valid, 1'b1);
            check_eq("wait_cycles", waits, (rv_delay >= 0) ? rv_delay + 1 : TO);
            if (mem_stall == 0 && rv_delay == 0) check_eq("resp_latency", cyc, 3);
        end

        entry = exp_q[0];
        rsp_ready = 1'b0;
        for (int s = 0; s < rsp_stall; s++) begin
            check_eq("stall_valid", rsp_valid, 1'b1);
            check_eq("stall_data", rsp_data, entry[68:37]);
            check_eq("stall_rd", rsp_rd, entry[73:69]);
            check_eq("stall_fault", rsp_fault, entry[75:74]);
            check_eq("stall_req_ready", req_ready, 1'b0);
            tick();
        end

        entry = exp_q.pop_front();
        check_eq("rsp_valid", rsp_valid, 1'b1);
        check_eq("rsp_data", rsp_data, entry[68:37]);
        check_eq("rsp_rd", rsp_rd, entry[73:69]);
        check_eq("rsp_fault", rsp_fault, entry[75:74]);
        check_eq("rsp_req_ready", req_ready, 1'b0);
        if (entry[75:74] != 2'b10) begin
            check_eq("sx_op", sx_op, entry[36:32]);
            check_eq("sx_unext", sx_unextended, entry[31:0]);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("back_idle_valid", rsp_valid, 1'b0);
        check_eq("back_idle_ready", req_ready, 1'b1);
        check_eq("back_idle_busy", busy, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_funct3    = '0;
        req_rd        = '0;
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        rsp_ready     = 1'b0;
        tick();
        tick();
        check_eq("rst_req_ready", req_ready, 1'b1);
        check_eq("rst_mem_req_valid", mem_req_valid, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rsp_fault", rsp_fault, 2'b00);
        check_eq("rst_rsp_data", rsp_data, 32'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_sx_op", sx_op, SX_3100);
        rst_n = 1'b1;
        tick();

        // Directed loads
        do_load(32'h0000_1003, 3'd0, 5'd7,  32'h80FF_1234, 0, 0, 0);   // LB
        do_load(32'h0000_2002, 3'd5, 5'd9,  32'h8001_0000, 0, 0, 0);   // LHU
        do_load(32'h0000_2002, 3'd1, 5'd10, 32'h8001_0000, 0, 0, 0);   // LH
        do_load(32'h0000_2000, 3'd2, 5'd11, 32'hDEAD_BEEF, 0, 0, 0);   // LW
        do_load(32'h0000_2001, 3'd2, 5'd12, 32'h1111_2222, 0, 0, 0);   // LW misaligned
        do_load(32'h0000_2001, 3'd3, 5'd13, 32'h1111_2222, 0, 0, 0);   // illegal funct3
        do_load(32'h0000_3001, 3'd4, 5'd14, 32'h0000_F500, 5, 3, 3);   // stalls both sides
        do_load(32'h0000_4000, 3'd2, 5'd15, 32'h1234_5678, 0, -1, 0);  // timeout

        // Late read data while idle must not create a response
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        check_eq("late_rvalid_rsp", rsp_valid, 1'b0);
        check_eq("late_rvalid_busy", busy, 1'b0);

        do_load(32'h0000_5003, 3'd0, 5'd16, 32'h7F00_0000, 0, 7, 0);   // rvalid on terminal count

        // Reset while waiting for read data
        req_valid  = 1'b1;
        req_addr   = 32'h0000_6000;
        req_funct3 = 3'd2;
        req_rd     = 5'd20;
        tick();
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check_eq("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("abort_req_ready", req_ready, 1'b1);
        check_eq("abort_rsp_valid", rsp_valid, 1'b0);
        check_eq("abort_busy", busy, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        tick();
        mem_rvalid = 1'b0;
        check_eq("abort_late_rsp", rsp_valid, 1'b0);
        tick();
        check_eq("abort_late_rsp2", rsp_valid, 1'b0);

        // Randomised tail
        for (int n = 0; n < 12; n++) begin
            do_load($urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, TO - 1), $urandom_range(0, 2));
        end

        check_eq("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
